// File: rtl/if_id_stage.sv
// if_id_stage: program counter, fetch address and IF/ID register with stall, redirect and squash
module if_id_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  output logic [31:0]      imem_addr,
  input  logic [31:0]      imem_data,
  input  logic             stall,
  input  logic             branch_taken,
  input  logic [31:0]      branch_target,
  input  logic             jump,
  input  logic [25:0]      j_address,
  output logic [31:0]      id_inst,
  output logic [31:0]      id_pc4,
  output logic             id_valid,
  output logic [CNT_W-1:0] fetch_cnt,
  output logic [CNT_W-1:0] bubble_cnt
);
  logic [31:0] pc, pc4, target;
  logic redirect;
  assign imem_addr = pc;
  assign pc4 = pc + 32'd4;
  assign redirect = jump | branch_taken;
  // jump region comes from the instruction sitting in ID, not from the fetch PC
  assign target = jump ? {id_pc4[31:28], j_address, 2'b00} : {branch_target[31:2], 2'b00};
  always_ff @(posedge clk) begin
    if (rst) begin
      pc <= RESET_PC;
      id_inst <= '0;
      id_pc4 <= '0;
      id_valid <= 1'b0;
      fetch_cnt <= '0;
      bubble_cnt <= '0;
    end else if (!stall) begin
      pc <= redirect ? target : pc4;
      id_inst <= redirect ? 32'h0 : imem_data;
      id_pc4 <= redirect ? 32'h0 : pc4;
      id_valid <= !redirect;
      fetch_cnt <= fetch_cnt + CNT_W'(!redirect);
      bubble_cnt <= bubble_cnt + CNT_W'(redirect);
    end
  end
endmodule

// File: tb/tb_if_id_stage.sv
// tb_if_id_stage: randomized fetch stimulus checked every cycle against an instruction-level model
module tb_if_id_stage;
  logic clk = 0, rst = 1, stall = 0, branch_taken = 0, jump = 0;
  logic [31:0] branch_target = 0, imem_addr, imem_data, id_inst, id_pc4;
  logic [25:0] j_address = 0;
  logic id_valid;
  logic [31:0] fetch_cnt, bubble_cnt;
  logic rst2 = 1, stall2 = 0;
  logic [31:0] imem_addr2, imem_data2, id_inst2, id_pc4_2, fetch_cnt2, bubble_cnt2;
  logic id_valid2;
  int total = 0, bad = 0;
  bit chk_en = 0;
  logic [31:0] m_pc, m_inst, m_pc4, m_fc, m_bc;
  logic m_valid;

  always #5 clk = ~clk;

  function automatic logic [31:0] mem(input logic [31:0] a);
    return a == 32'h0 ? 32'h8c01_0014 : a == 32'h4 ? 32'h8c02_0015 : (a ^ 32'hDEAD_0000) + {a[7:0], 24'h0};
  endfunction

  assign imem_data = mem(imem_addr);
  assign imem_data2 = mem(imem_addr2);

  if_id_stage dut (.clk(clk), .rst(rst), .imem_addr(imem_addr), .imem_data(imem_data), .stall(stall),
    .branch_taken(branch_taken), .branch_target(branch_target), .jump(jump), .j_address(j_address),
    .id_inst(id_inst), .id_pc4(id_pc4), .id_valid(id_valid), .fetch_cnt(fetch_cnt), .bubble_cnt(bubble_cnt));

  if_id_stage #(.RESET_PC(32'hFFFF_FFFC)) dut2 (.clk(clk), .rst(rst2), .imem_addr(imem_addr2),
    .imem_data(imem_data2), .stall(stall2), .branch_taken(1'b0), .branch_target(32'h0), .jump(1'b0),
    .j_address(26'h0), .id_inst(id_inst2), .id_pc4(id_pc4_2), .id_valid(id_valid2),
    .fetch_cnt(fetch_cnt2), .bubble_cnt(bubble_cnt2));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // one edge of the reference: what the stage must hold after this clock
  task automatic step();
    @(posedge clk);
    if (rst) begin
      m_pc = 0; m_inst = 0; m_pc4 = 0; m_valid = 0; m_fc = 0; m_bc = 0;
    end else if (!stall) begin
      if (jump || branch_taken) begin
        m_pc = jump ? {m_pc4[31:28], j_address, 2'b00} : {branch_target[31:2], 2'b00};
        m_inst = 0; m_pc4 = 0; m_valid = 0; m_bc++;
      end else begin
        m_inst = mem(m_pc); m_pc4 = m_pc + 4; m_pc = m_pc + 4; m_valid = 1; m_fc++;
      end
    end
    #2;
  endtask

  always @(negedge clk) if (chk_en) begin
    chk("imem_addr", imem_addr, m_pc);
    chk("id_inst", id_inst, m_inst);
    chk("id_pc4", id_pc4, m_pc4);
    chk("id_valid", {31'h0, id_valid}, {31'h0, m_valid});
    chk("fetch_cnt", fetch_cnt, m_fc);
    chk("bubble_cnt", bubble_cnt, m_bc);
  end

  initial begin
    step(); step();
    chk_en = 1;
    chk("reset valid", {31'h0, id_valid}, 32'h0);
    chk("reset addr", imem_addr, 32'h0);
    rst = 0;
    step();
    chk("e1 inst", id_inst, 32'h8c01_0014);
    chk("e1 pc4", id_pc4, 32'h4);
    chk("e1 valid", {31'h0, id_valid}, 32'h1);
    chk("e1 addr", imem_addr, 32'h4);
    step();
    chk("e2 inst", id_inst, 32'h8c02_0015);
    chk("e2 pc4", id_pc4, 32'h8);
    chk("e2 fcnt", fetch_cnt, 32'd2);
    stall = 1;
    repeat (3) step();
    chk("stall addr", imem_addr, 32'h8);
    chk("stall inst", id_inst, 32'h8c02_0015);
    chk("stall fcnt", fetch_cnt, 32'd2);
    chk("stall bcnt", bubble_cnt, 32'd0);
    stall = 0;
    step();
    chk("post stall pc4", id_pc4, 32'hC);
    chk("post stall addr", imem_addr, 32'hC);
    branch_taken = 1; branch_target = 32'h43;
    step();
    chk("br addr", imem_addr, 32'h40);
    chk("br inst", id_inst, 32'h0);
    chk("br valid", {31'h0, id_valid}, 32'h0);
    chk("br bcnt", bubble_cnt, 32'd1);
    branch_taken = 0;
    step();
    chk("br tgt pc4", id_pc4, 32'h44);
    chk("br tgt inst", id_inst, 32'h40 ^ 32'hDEAD_0000 + 32'h4000_0000);
    branch_taken = 1; branch_target = 32'h3000_000C;
    step();
    branch_taken = 0;
    step();
    chk("pre jump pc4", id_pc4, 32'h3000_0010);
    jump = 1; j_address = 26'h100; branch_taken = 1; branch_target = 32'h80;
    step();
    chk("jump wins", imem_addr, 32'h3000_0400);
    jump = 0;
    stall = 1;
    step();
    chk("masked addr", imem_addr, 32'h3000_0400);
    chk("masked bcnt", bubble_cnt, 32'd3);
    stall = 0; branch_taken = 0;
    repeat (400) begin
      stall = $urandom_range(0, 3) == 0;
      branch_taken = $urandom_range(0, 9) == 0;
      jump = $urandom_range(0, 19) == 0;
      branch_target = $urandom;
      j_address = 26'($urandom);
      rst = $urandom_range(0, 49) == 0;
      step();
    end
    rst = 0; stall = 0; branch_taken = 0; jump = 0;
    step();
    chk_en = 0;
    step();
    chk("wrap rst addr", imem_addr2, 32'hFFFF_FFFC);
    rst2 = 0;
    step();
    chk("wrap addr", imem_addr2, 32'h0);
    chk("wrap pc4", id_pc4_2, 32'h0);
    chk("wrap valid", {31'h0, id_valid2}, 32'h1);
    chk("wrap inst", id_inst2, mem(32'hFFFF_FFFC));
    stall2 = 1;
    step();
    rst2 = 1;
    step();
    chk("mid rst addr", imem_addr2, 32'hFFFF_FFFC);
    chk("mid rst valid", {31'h0, id_valid2}, 32'h0);
    chk("mid rst fcnt", fetch_cnt2, 32'h0);
    chk("mid rst bcnt", bubble_cnt2, 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end
endmodule

// File: doc/if_id_stage.md
Name: if_id_stage

Overview:
Instruction-fetch stage plus IF/ID pipeline register for the 5-stage MIPS pipeline. It holds the PC, drives the instruction-memory address, and latches the fetched word and PC+4 into the register whose `id_inst` output feeds the control unit's `inst` input. It honours hazard-unit stalls and applies branch/jump redirects resolved in ID. Every redirect squashes the wrong-path fetch. There is no architectural delay slot.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
CNT_W, 32, width of performance counters

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous active-high reset
imem_addr  out  32  instruction memory address, equals current PC
imem_data  in  32  instruction word, combinational read of imem_addr, valid in the same cycle
stall  in  1  hazard unit: hold PC and IF/ID register
branch_taken  in  1  branch in ID resolved taken
branch_target  in  32  branch target address from ID
jump  in  1  J-type instruction in ID (control unit decode)
j_address  in  26  jump index field from the control unit
id_inst  out  32  IF/ID instruction, goes to control unit `inst`
id_pc4  out  32  IF/ID PC+4
id_valid  out  1  IF/ID holds a real fetched instruction
fetch_cnt  out  CNT_W  instructions latched into IF/ID
bubble_cnt  out  CNT_W  cycles IF/ID was loaded with a squash bubble

Behaviour:
- Reset (sampled on clk edge while rst=1):
  - pc = RESET_PC
  - id_inst = 32'h0000_0000 (NOP, sll $0,$0,0)
  - id_pc4 = 0, id_valid = 0
  - fetch_cnt = 0, bubble_cnt = 0
  - rst mid-stall or mid-redirect overrides everything.
- imem_addr = pc at all times, combinational from the PC register.
- Per-edge priority is rst > stall > redirect > sequential.
- Stall (stall=1):
  - pc, id_inst, id_pc4, id_valid and both counters hold.
  - branch_taken/jump are ignored, because the ID instruction is re-presented next cycle and re-resolves then.
- Redirect (stall=0 and (jump=1 or branch_taken=1)):
  - Target if jump=1: {id_pc4[31:28], j_address, 2'b00}.
  - Otherwise the target is {branch_target[31:2], 2'b00}; the low bits are forced to 0.
  - jump wins if both are asserted.
  - pc <= target.
  - id_inst <= 0, id_valid <= 0, id_pc4 <= 0. This squashes the instruction fetched this cycle.
  - bubble_cnt += 1.
  - Penalty is exactly one bubble cycle. On the next edge the target instruction enters IF/ID.
- Sequential (stall=0, no redirect):
  - pc <= pc + 4.
  - id_inst <= imem_data, id_pc4 <= pc + 4, id_valid <= 1.
  - fetch_cnt += 1.
- PC arithmetic is modulo 2^32: 32'hFFFF_FFFC + 4 gives 0, and id_pc4 = 0 in that case.
- Counters wrap modulo 2^CNT_W silently.
- Outputs are registered except imem_addr. There are no combinational paths from inputs to outputs.
- Latency: an instruction at address A appears on id_inst one edge after pc = A with stall=0.
- A redirect with id_valid=0 is legal (no qualification) but never occurs when decode is driven correctly.

Test Plan:
- Reset and sequential fetch: rst for 2 cycles, then release; imem returns 32'h8c010014 at 0 and 32'h8c020015 at 4.
  - After edge 1: id_inst = 8c010014, id_pc4 = 4, id_valid = 1, imem_addr = 4.
  - After edge 2: id_inst = 8c020015, id_pc4 = 8, fetch_cnt = 2.
- Stall: assert stall for 3 cycles at pc = 8.
  - imem_addr stays at 8, id_inst holds 8c020015, and the counters are unchanged.
  - On release, the next edge loads the word at 8 and imem_addr = 12.
- Branch redirect: branch_taken = 1, branch_target = 32'h0000_0043.
  - pc becomes 32'h40, id_inst = 0, id_valid = 0, bubble_cnt = 1.
  - The next edge latches the word at 0x40 with id_pc4 = 0x44.
- Jump plus branch together: id_pc4 = 32'h3000_0010, jump = 1, j_address = 26'h000_0100, branch_taken = 1, branch_target = 0x80.
  - pc becomes 32'h3000_0400 (jump wins).
- Stall masking a redirect: stall = 1 and branch_taken = 1 in the same cycle.
  - pc and IF/ID are unchanged and bubble_cnt is unchanged.
- Wrap and mid-stream reset: RESET_PC = 32'hFFFF_FFFC; one sequential edge gives pc = 0 and id_pc4 = 0.
  - Then assert rst during stall = 1: pc = RESET_PC, id_valid = 0, and the counters return to 0.
